// File: rtl/card_dealer.sv
// Card dealer: LFSR shuffle while control is held, distinct-card deal from a
// tracked 52-card deck on release, multiplexed face/suit glyph scan-out.
module card_dealer #(
   parameter int          NUM_CARDS = 4,
   parameter int          SCAN_DIV  = 250000,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   control,
   output logic [2*NUM_CARDS-1:0] turn,
   output logic [7:0]             display_0,
   output logic [7:0]             display_1,
   output logic                   busy,
   output logic                   hand_valid,
   output logic                   reshuffled,
   output logic [5:0]             cards_left
);

   localparam int SLOTS = 2 * NUM_CARDS;
   localparam int S_W   = $clog2(SLOTS);
   localparam int K_W   = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHUFFLE = 2'd1,
      ST_DRAW    = 2'd2,
      ST_SHOW    = 2'd3
   } state_t;

   state_t               state_r;
   logic [7:0]           lfsr_r;
   logic [51:0]          used_r;
   logic [5:0]           cards_left_r;
   logic [K_W-1:0]       k_r;
   logic [5:0]           hand_r [NUM_CARDS];
   logic [NUM_CARDS-1:0] hand_ok_r;
   logic                 busy_r;
   logic                 hand_valid_r;
   logic                 reshuffled_r;

   logic [DIV_W-1:0]     div_r;
   logic [S_W-1:0]       slot_r;
   logic [SLOTS-1:0]     turn_r;
   logic [7:0]           disp_r;

   logic [7:0]           lfsr_next_s;
   logic [5:0]           cand_s;
   logic                 cand_ok_s;
   logic                 last_k_s;
   logic                 tick_s;
   logic [S_W-1:0]       slot_next_s;
   logic [K_W-1:0]       hidx_s;
   logic [5:0]           card_s;
   logic [7:0]           glyph_s;

   function automatic logic [1:0] card_suit(input logic [5:0] idx);
      if (idx >= 6'd39)      return 2'd3;
      else if (idx >= 6'd26) return 2'd2;
      else if (idx >= 6'd13) return 2'd1;
      else                   return 2'd0;
   endfunction

   // Face 1..13; low-nibble arithmetic is exact because the result is < 16.
   function automatic logic [3:0] card_face(input logic [5:0] idx);
      if (idx >= 6'd39)      return idx[3:0] - 4'd6;
      else if (idx >= 6'd26) return idx[3:0] - 4'd9;
      else if (idx >= 6'd13) return idx[3:0] - 4'd12;
      else                   return idx[3:0] + 4'd1;
   endfunction

   function automatic logic [7:0] face_glyph(input logic [3:0] face);
      case (face)
         4'd1:    return 8'hEF;
         4'd2:    return 8'hDA;
         4'd3:    return 8'hF2;
         4'd4:    return 8'h66;
         4'd5:    return 8'hB6;
         4'd6:    return 8'hBE;
         4'd7:    return 8'hE4;
         4'd8:    return 8'hFE;
         4'd9:    return 8'hF6;
         4'd10:   return 8'h6C;
         4'd11:   return 8'hF1;
         4'd12:   return 8'hD7;
         4'd13:   return 8'hDD;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] suit_glyph(input logic [1:0] suit);
      case (suit)
         2'd0:    return 8'h97;
         2'd1:    return 8'h6F;
         2'd2:    return 8'hBB;
         2'd3:    return 8'h9D;
         default: return 8'h00;
      endcase
   endfunction

   // Candidate evaluation, LFSR successor and scan-glyph selection.
   always_comb begin
      lfsr_next_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      cand_s      = lfsr_r[5:0];
      if (cand_s < 6'd52) cand_ok_s = !used_r[cand_s];
      else                cand_ok_s = 1'b0;
      last_k_s    = (k_r == K_W'(NUM_CARDS - 1));
      tick_s      = (div_r == DIV_W'(SCAN_DIV - 1));
      if (slot_r == S_W'(SLOTS - 1)) slot_next_s = {S_W{1'b0}};
      else                           slot_next_s = slot_r + S_W'(1);
      hidx_s = K_W'(slot_next_s >> 1);
      card_s = hand_r[hidx_s];
      if (!hand_ok_r[hidx_s])   glyph_s = 8'h00;
      else if (slot_next_s[0])  glyph_s = suit_glyph(card_suit(card_s));
      else                      glyph_s = face_glyph(card_face(card_s));
   end

   // Dealer FSM with deck bitmap, hand storage and status outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         lfsr_r       <= LFSR_SEED;
         used_r       <= 52'd0;
         cards_left_r <= 6'd52;
         k_r          <= {K_W{1'b0}};
         hand_ok_r    <= {NUM_CARDS{1'b0}};
         busy_r       <= 1'b0;
         hand_valid_r <= 1'b0;
         reshuffled_r <= 1'b0;
         for (int i = 0; i < NUM_CARDS; i++) hand_r[i] <= 6'd0;
      end else begin
         reshuffled_r <= 1'b0;
         if (state_r == ST_SHUFFLE || state_r == ST_DRAW) lfsr_r <= lfsr_next_s;
         case (state_r)
            ST_IDLE: begin
               if (control) state_r <= ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
               if (!control) begin
                  state_r      <= ST_DRAW;
                  busy_r       <= 1'b1;
                  hand_valid_r <= 1'b0;
                  k_r          <= {K_W{1'b0}};
                  hand_ok_r    <= {NUM_CARDS{1'b0}};
                  // Refill only when the remaining deck cannot cover a full hand.
                  if (cards_left_r < 6'(NUM_CARDS)) begin
                     used_r       <= 52'd0;
                     cards_left_r <= 6'd52;
                     reshuffled_r <= 1'b1;
                  end
               end
            end
            ST_DRAW: begin
               if (cand_ok_s) begin
                  hand_r[k_r]    <= cand_s;
                  hand_ok_r[k_r] <= 1'b1;
                  used_r[cand_s] <= 1'b1;
                  cards_left_r   <= cards_left_r - 6'd1;
                  if (last_k_s) begin
                     state_r      <= ST_SHOW;
                     busy_r       <= 1'b0;
                     hand_valid_r <= 1'b1;
                     k_r          <= {K_W{1'b0}};
                  end else begin
                     k_r <= k_r + K_W'(1);
                  end
               end
            end
            ST_SHOW: begin
               if (control) state_r <= ST_SHUFFLE;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Scan divider, digit rotation and glyph registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_r  <= {DIV_W{1'b0}};
         slot_r <= {S_W{1'b0}};
         turn_r <= SLOTS'(1);
         disp_r <= 8'h00;
      end else if (tick_s) begin
         div_r  <= {DIV_W{1'b0}};
         slot_r <= slot_next_s;
         turn_r <= {turn_r[SLOTS-2:0], turn_r[SLOTS-1]};
         disp_r <= glyph_s;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   assign turn       = turn_r;
   assign display_0  = disp_r;
   assign display_1  = disp_r;
   assign busy       = busy_r;
   assign hand_valid = hand_valid_r;
   assign reshuffled = reshuffled_r;
   assign cards_left = cards_left_r;

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Parametrised card dealer for the lab board. While `control` is held it shuffles with a free-running LFSR. On release it deals NUM_CARDS distinct cards from a tracked 52-card deck, with no repeats until the deck is refilled. The dealt hand is then scanned onto the two mirrored 7-segment banks as alternating face and suit glyphs, with a one-hot `turn` digit select.

Parameters:
NUM_CARDS, 4, cards per hand; legal 1..13.
SCAN_DIV, 250000, clock cycles per scan step (400 Hz at 100 MHz).
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
clock  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
control  input  1  high = shuffle; falling edge (1->0, sampled on clock) starts a deal.
turn  output  2*NUM_CARDS  one-hot digit select.
display_0  output  8  segment pattern, bank 0.
display_1  output  8  segment pattern, bank 1; always equal to display_0.
busy  output  1  high while the FSM is in DRAW.
hand_valid  output  1  high in SHOW after a complete deal.
reshuffled  output  1  one-cycle pulse when the used-card bitmap is cleared.
cards_left  output  6  undealt cards in the deck, 0..52.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; lfsr=LFSR_SEED; used bitmap (52 bits) cleared; cards_left=52.
  - hand slots invalid; turn=1; display_0=display_1=8'h00; busy=0; hand_valid=0; reshuffled=0.
  - Scan divider=0.
- LFSR:
  - 8-bit, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances every clock in SHUFFLE and DRAW; holds otherwise.
  - Maximal length, period 255.
- Card encoding:
  - Index i in 0..51; face = (i mod 13)+1; suit = i/13.
  - Suit codes: 0 spade, 1 heart, 2 diamond, 3 club.
- FSM states:
  - IDLE: control=1 -> SHUFFLE.
  - SHUFFLE: control=1 stays; control=0 -> DRAW, with k=0 and hand_valid=0.
    - On DRAW entry, if cards_left < NUM_CARDS: clear bitmap, cards_left=52, pulse reshuffled for that cycle.
  - DRAW: busy=1; candidate = lfsr[5:0].
    - Accept if candidate < 52 and not used: hand[k]=candidate, set used bit, cards_left-1, k+1. Otherwise retry next cycle.
    - One accept per cycle at most.
    - After the accept with k=NUM_CARDS-1 -> SHOW; hand_valid=1.
    - Each draw completes within 255 cycles, since all 64 6-bit values occur in one LFSR period. A full deal completes within NUM_CARDS*255 cycles.
    - control is ignored in DRAW.
  - SHOW: scan the hand; control=1 -> SHUFFLE (hand_valid stays 1 until the next DRAW entry).
- Scan:
  - Divider counts 0..SCAN_DIV-1 in all states; the tick is at wrap.
  - On tick: turn rotates left with wrap (MSB -> bit 0).
  - Displays show the glyph for the currently one-hot slot s:
    - even s = face of hand[s/2];
    - odd s = suit of hand[s/2];
    - invalid slot = 8'h00.
  - Display registers update on the tick only.
- Face glyphs 1..13: EF, DA, F2, 66, B6, BE, E4, FE, F6, 6C, F1, D7, DD (hex).
- Suit glyphs 0..3: 97, 6F, BB, 9D (hex).
- Reset mid-DRAW aborts the deal. The partial hand and bitmap are discarded (bitmap cleared, cards_left=52).
- control glitching 0->1->0 inside SHUFFLE restarts nothing; only the falling edge into DRAW counts.

Test Plan:
- Reset held, then released -> turn=1, displays 8'h00, cards_left=52, hand_valid=0, busy=0, lfsr=8'hA5.
- NUM_CARDS=4, SCAN_DIV=4: control high 10 cycles, then low -> busy within 1 cycle; hand_valid within 1020 cycles. Cards are 4 distinct indices <52 that match the reference LFSR model; cards_left=48.
- After a deal, run 8 scan ticks -> turn steps 01,02,04,...,80,01. Displays equal the face/suit glyph of each slot; display_0==display_1 throughout.
- 13 consecutive deals (52 cards) -> no index repeats across deals; cards_left=0. The 14th deal pulses reshuffled for exactly 1 cycle and ends with cards_left=48.
- Assert reset while busy=1 -> immediate turn=1, displays 8'h00, busy=0, cards_left=52.
- Toggle control during DRAW -> deal unaffected; FSM reaches SHOW, then returns to SHUFFLE on the next control=1.
